// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg : shared helpers and types for the extended FIFO controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Never returns 0 so a depth of 1 still gets a usable address bit.
    function automatic int clog2_safe(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem : register-array storage, synchronous write, asynchronous read
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_mem #(
    parameter int SIZE_DATA  = 8,
    parameter int SIZE_DEPTH = 16,
    parameter int SIZE_ADDR  = 4
) (
    input  logic                 i_clk,
    input  logic                 i_wr_en,
    input  logic [SIZE_ADDR-1:0] i_wr_addr,
    input  logic [SIZE_DATA-1:0] i_wr_data,
    input  logic [SIZE_ADDR-1:0] i_rd_addr,
    output logic [SIZE_DATA-1:0] o_rd_data
);

    logic [SIZE_DATA-1:0] mem_q [SIZE_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem_q[i_rd_addr];

endmodule

`default_nettype wire

// File: rtl/fifo_ctrl_ext.sv
// ---------------------------------------------------------------------------
// fifo_ctrl_ext : synchronous FIFO with FWFT option, thresholds, count,
//                 sticky error flags and synchronous flush
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_ctrl_ext
    import fifo_pkg::*;
#(
    parameter int SIZE_DATA  = 8,
    parameter int SIZE_DEPTH = 16,
    parameter int AF_TH      = 12,
    parameter int AE_TH      = 2,
    parameter int FWFT       = 0
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_flush,
    input  logic                             i_wr_en,
    input  logic                             i_rd_en,
    input  logic [SIZE_DATA-1:0]             i_data,
    output logic [SIZE_DATA-1:0]             o_data,
    output logic                             o_valid,
    output logic                             o_fifo_full,
    output logic                             o_fifo_empty,
    output logic                             o_almost_full,
    output logic                             o_almost_empty,
    output logic [clog2_safe(SIZE_DEPTH):0]  o_count,
    output logic                             o_overflow,
    output logic                             o_underflow
);

    localparam int SIZE_ADDR = clog2_safe(SIZE_DEPTH);

    typedef logic [SIZE_ADDR:0] ptr_t;

    localparam ptr_t AF_LVL = ptr_t'(AF_TH);
    localparam ptr_t AE_LVL = ptr_t'(AE_TH);

    ptr_t ptr_wr_q, ptr_wr_d;
    ptr_t ptr_rd_q, ptr_rd_d;
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_rd_acc;
    logic                 w_wr_acc;
    ptr_t                 w_count;
    logic [SIZE_DATA-1:0] w_rd_data;

    // Pointer difference is the occupancy; the wrap bit makes DEPTH representable.
    assign w_count  = ptr_wr_q - ptr_rd_q;
    assign w_empty  = (ptr_wr_q == ptr_rd_q);
    assign w_full   = (ptr_wr_q[SIZE_ADDR-1:0] == ptr_rd_q[SIZE_ADDR-1:0]) &&
                      (ptr_wr_q[SIZE_ADDR] != ptr_rd_q[SIZE_ADDR]);
    assign w_rd_acc = i_rd_en & ~w_empty;
    assign w_wr_acc = i_wr_en & (~w_full | w_rd_acc);

    always_comb begin
        ptr_wr_d    = ptr_wr_q + ptr_t'(w_wr_acc);
        ptr_rd_d    = ptr_rd_q + ptr_t'(w_rd_acc);
        overflow_d  = overflow_q  | (i_wr_en & ~w_wr_acc);
        underflow_d = underflow_q | (i_rd_en & ~w_rd_acc);
        if (i_flush) begin
            ptr_wr_d    = '0;
            ptr_rd_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_wr_q    <= '0;
            ptr_rd_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            ptr_wr_q    <= ptr_wr_d;
            ptr_rd_q    <= ptr_rd_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .SIZE_DATA  (SIZE_DATA),
        .SIZE_DEPTH (SIZE_DEPTH),
        .SIZE_ADDR  (SIZE_ADDR)
    ) u_mem (
        .i_clk     (i_clk),
        .i_wr_en   (w_wr_acc & ~i_flush),
        .i_wr_addr (ptr_wr_q[SIZE_ADDR-1:0]),
        .i_wr_data (i_data),
        .i_rd_addr (ptr_rd_q[SIZE_ADDR-1:0]),
        .o_rd_data (w_rd_data)
    );

    generate
        if (FWFT == int'(FIFO_FWFT)) begin : g_fwft
            assign o_data  = w_rd_data;
            assign o_valid = ~w_empty;
        end else begin : g_std
            logic [SIZE_DATA-1:0] data_q;
            logic                 valid_q;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else if (i_flush) begin
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= w_rd_acc;
                    if (w_rd_acc) begin
                        data_q <= w_rd_data;
                    end
                end
            end

            assign o_data  = data_q;
            assign o_valid = valid_q;
        end
    endgenerate

    assign o_count        = w_count;
    assign o_fifo_empty   = w_empty;
    assign o_fifo_full    = w_full;
    assign o_almost_full  = (w_count >= AF_LVL);
    assign o_almost_empty = (w_count <= AE_LVL);
    assign o_overflow     = overflow_q;
    assign o_underflow    = underflow_q;

endmodule

`default_nettype wire
